// File: rtl/a2d_pkg.sv
// Shared types and ADC channel numbers for the A/D round-robin controller.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNV_SND,
        CNV_WAIT,
        GAP,
        RD_SND,
        RD_WAIT
    } state_t;

    localparam logic [2:0] CH_BATT   = 3'd0;
    localparam logic [2:0] CH_CURR   = 3'd1;
    localparam logic [2:0] CH_BRAKE  = 3'd3;
    localparam logic [2:0] CH_TORQUE = 3'd4;

    function automatic logic [2:0] chnl_of(input logic [1:0] idx);
        case (idx)
            2'd0:    chnl_of = CH_BATT;
            2'd1:    chnl_of = CH_CURR;
            2'd2:    chnl_of = CH_BRAKE;
            default: chnl_of = CH_TORQUE;
        endcase
    endfunction

endpackage

// File: rtl/a2d_intf.sv
// Round-robin SPI A/D controller: converts batt/curr/brake/torque, one channel per timer wrap.
// Latency: result visible the cycle after RD_WAIT sees done; one round = two SPI transactions.
// Backpressure: waits on the transceiver's done; a timer wrap arriving while busy is dropped.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int TMR_W = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        snd,
    output logic [15:0] cmd,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque
);

    logic [TMR_W-1:0] tmr;
    logic [1:0]       idx;
    state_t           state_q, state_d;
    logic             start_cnv;
    logic             load_cmd;
    logic             capture;

    assign start_cnv = &tmr;

    // done is only looked at in the WAIT states, so a done left high by the
    // previous transaction is never mistaken for completion.
    always_comb begin
        state_d  = state_q;
        load_cmd = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_cnv) begin
                    load_cmd = 1'b1;
                    state_d  = CNV_SND;
                end
            end
            CNV_SND:  state_d = CNV_WAIT;
            CNV_WAIT: if (done) state_d = GAP;
            GAP:      state_d = RD_SND;
            RD_SND:   state_d = RD_WAIT;
            RD_WAIT: begin
                if (done) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    assign snd = (state_q == CNV_SND) || (state_q == RD_SND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr     <= '0;
            state_q <= IDLE;
            idx     <= 2'd0;
            cmd     <= 16'h0000;
            batt    <= 12'h000;
            curr    <= 12'h000;
            brake   <= 12'h000;
            torque  <= 12'h000;
        end else begin
            tmr     <= tmr + TMR_W'(1);
            state_q <= state_d;
            if (load_cmd) begin
                cmd <= {2'b00, chnl_of(idx), 11'h000};
            end
            if (capture) begin
                case (idx)
                    2'd0:    batt   <= resp[11:0];
                    2'd1:    curr   <= resp[11:0];
                    2'd2:    brake  <= resp[11:0];
                    default: torque <= resp[11:0];
                endcase
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: behavioural SPI transceiver/ADC plus a round-level timing model.
module tb_a2d_intf;

    localparam int TMR_W = 4;
    localparam int PER   = 1 << TMR_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic        snd;
    logic [15:0] cmd;
    logic [11:0] batt, curr, brake, torque;

    a2d_intf #(.TMR_W(TMR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .done   (done),
        .resp   (resp),
        .snd    (snd),
        .cmd    (cmd),
        .batt   (batt),
        .curr   (curr),
        .brake  (brake),
        .torque (torque)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n      = 0;

    // round-level model: a round starts on a timer wrap seen while idle
    bit          busy;
    int          s1, s2, fin, prev_s1, last_gap;
    int          rr;
    logic [11:0] res [4];
    logic [15:0] cur_cmd;
    int          lat, lat_lo, lat_hi;
    int          ch_map [4] = '{0, 1, 3, 4};

    // transceiver/ADC model state
    bit          snd_prev;
    logic [15:0] cmd_prev, xcmd, last_resp;
    int          xcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    endtask

    task automatic step();
        logic exp_snd;
        @(posedge clk);
        #1;
        n++;
        // transceiver clears done on the edge ending snd, raises it lat edges later
        if (snd_prev) begin
            done = 1'b0;
            xcnt = lat;
            xcmd = cmd_prev;
        end else if (xcnt > 0) begin
            xcnt--;
            if (xcnt == 0) begin
                done      = 1'b1;
                resp      = (xcmd[13:11] == 3'd1) ? 16'hFABC : 16'($urandom);
                last_resp = resp;
            end
        end
        @(negedge clk);
        if (busy && n == fin) begin
            res[rr] = last_resp[11:0];
            rr      = (rr + 1) % 4;
            busy    = 1'b0;
        end
        if (!busy && (n % PER) == PER - 1) begin
            busy = 1'b1;
            s1   = n + 1;
            lat  = $urandom_range(lat_hi, lat_lo);
            s2   = s1 + lat + 3;
            fin  = s2 + lat + 2;
            if (prev_s1 > 0) last_gap = s1 - prev_s1;
            prev_s1 = s1;
        end
        if (busy && n == s1) cur_cmd = {2'b00, 3'(ch_map[rr]), 11'h000};
        exp_snd = busy && (n == s1 || n == s2);
        if (snd || exp_snd) check_eq("snd", snd, exp_snd);
        check_eq("cmd", cmd, cur_cmd);
        check_eq("batt", batt, res[0]);
        check_eq("curr", curr, res[1]);
        check_eq("brake", brake, res[2]);
        check_eq("torque", torque, res[3]);
        snd_prev = snd;
        cmd_prev = cmd;
    endtask

    task automatic do_reset(input int lo, input int hi);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        done = 1'b0; resp = 16'h0000;
        busy = 1'b0; rr = 0; cur_cmd = 16'h0000;
        prev_s1 = 0; last_gap = 0;
        snd_prev = 1'b0; xcnt = 0;
        for (int i = 0; i < 4; i++) res[i] = 12'h000;
        lat_lo = lo; lat_hi = hi; lat = lo;
        check_eq("rst_snd", snd, 1'b0);
        check_eq("rst_cmd", cmd, 16'h0000);
        check_eq("rst_batt", batt, 12'h000);
        check_eq("rst_curr", curr, 12'h000);
        check_eq("rst_brake", brake, 12'h000);
        check_eq("rst_torque", torque, 12'h000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    initial begin
        bit hit;
        int first_n;

        // five short rounds: ch0, ch1 (0xFABC), ch3, ch4, ch0 again
        do_reset(1, 3);
        repeat (100) step();
        check_eq("curr_abc", curr, 12'hABC);
        check_eq("round_gap", last_gap, PER);

        // reset in RD_WAIT of the first torque round
        do_reset(1, 3);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            hit = busy && rr == 3 && n > s2 && n < fin;
        end
        check_eq("midrst_reached", hit, 1'b1);
        check_eq("torque_pre_rst", torque, 12'h000);
        do_reset(10, 12);
        hit = 1'b0;
        first_n = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (snd) begin
                hit = 1'b1;
                first_n = n;
                check_eq("first_cmd_after_rst", cmd, 16'h0000);
            end
        end
        check_eq("first_snd_seen", hit, 1'b1);
        check_eq("first_snd_edge", first_n, PER);
        check_eq("torque_after_rst", torque, 12'h000);

        // long transactions: each round outlasts one timer period
        repeat (150) step();
        check_eq("overlap_gap", last_gap, 2 * PER);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
